// File: rtl/am_meas_ctrl_if.sv
// am_meas_ctrl_if -- control and result signals of the AM measurement controller.
//   start, abort       : measurement request / cancel (driven by the controller's master)
//   ma_in, freq_in     : modulation depth (%) and modulating frequency (kHz) from the demodulator
//   demod_en           : demodulator enable
//   busy               : measurement in progress
//   res_valid          : one-cycle pulse when res_ma/res_freq update
//   res_ma, res_freq   : averaged depth and measured frequency
//   err                : measurement failed, held until the next accepted start
interface am_meas_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] ma_in;
  logic [7:0] freq_in;
  logic       demod_en;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_ma;
  logic [7:0] res_freq;
  logic       err;

  modport master (
    output start, abort, ma_in, freq_in,
    input  demod_en, busy, res_valid, res_ma, res_freq, err
  );

  modport slave (
    input  start, abort, ma_in, freq_in,
    output demod_en, busy, res_valid, res_ma, res_freq, err
  );
endinterface

// File: rtl/am_meas_ctrl.sv
// am_meas_ctrl -- AM measurement sequencer.
// Enables the demodulator, waits SETTLE_CYC cycles, then samples ma/freq once per
// WIN_CYC-cycle window. N_AVG consecutive stable samples are averaged into res_ma;
// an unstable sample restarts the average, and MAX_TRY restarts end in ERR.
// Ports:
//   clk  : 8.192 MHz system clock (only clock)
//   rst  : asynchronous active-high reset
//   bus  : am_meas_ctrl_if.slave (start/abort/ma_in/freq_in in, results/status out)
module am_meas_ctrl #(
  parameter int SETTLE_CYC = 8192,
  parameter int WIN_CYC    = 8192,
  parameter int N_AVG      = 4,
  parameter int MA_TOL     = 2,
  parameter int MAX_TRY    = 8
) (
  input logic           clk,
  input logic           rst,
  am_meas_ctrl_if.slave bus
);

  localparam int LOG2N = $clog2(N_AVG);
  localparam int AW    = 8 + LOG2N;
  localparam int MAXC  = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int SW    = $clog2(N_AVG + 1);
  localparam int TW    = $clog2(MAX_TRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t         state_r, state_prev_r, next_state_s;
  logic [CW-1:0]  cyc_cnt_r;
  logic [SW-1:0]  samp_cnt_r;
  logic [TW-1:0]  try_cnt_r;
  logic [AW-1:0]  acc_r;
  logic [7:0]     prev_ma_r;
  logic [7:0]     prev_freq_r;

  logic           demod_en_r, busy_r, res_valid_r, err_r;
  logic [7:0]     res_ma_r, res_freq_r;

  logic           demod_en_s, busy_s, res_valid_s, err_s;
  logic           start_ok_s, settle_tc_s, win_tc_s, stable_s, samp_full_s;
  logic [7:0]     ma_c_s, ma_diff_s;
  logic [TW-1:0]  try_inc_s;

  assign bus.demod_en  = demod_en_r;
  assign bus.busy      = busy_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_ma    = res_ma_r;
  assign bus.res_freq  = res_freq_r;
  assign bus.err       = err_r;

  // Sample qualification: clamp, distance from previous sample, terminal counts.
  always_comb begin
    ma_c_s      = (bus.ma_in > 8'd100) ? 8'd100 : bus.ma_in;
    ma_diff_s   = (ma_c_s >= prev_ma_r) ? (ma_c_s - prev_ma_r) : (prev_ma_r - ma_c_s);
    // The first sample of a run has nothing to compare against.
    stable_s    = (samp_cnt_r == SW'(0)) ||
                  ((ma_diff_s <= 8'(MA_TOL)) && (bus.freq_in == prev_freq_r));
    samp_full_s = (samp_cnt_r == SW'(N_AVG));
    settle_tc_s = (cyc_cnt_r == CW'(SETTLE_CYC - 1));
    win_tc_s    = (cyc_cnt_r == CW'(WIN_CYC - 1));
    try_inc_s   = try_cnt_r + TW'(1);
    // abort outranks start in every state.
    start_ok_s  = bus.start && !bus.abort &&
                  ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
  end

  // State register plus previous-state copy used to detect DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      state_prev_r <= ST_IDLE;
    end else begin
      state_r      <= next_state_s;
      state_prev_r <= state_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    if (bus.abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) next_state_s = ST_SETTLE;
          else           next_state_s = state_r;
        end
        ST_SETTLE: begin
          if (settle_tc_s) next_state_s = ST_SAMPLE;
          else             next_state_s = ST_SETTLE;
        end
        ST_SAMPLE: begin
          if (samp_full_s)
            next_state_s = ST_DONE;
          else if (win_tc_s && !stable_s && (try_inc_s == TW'(MAX_TRY)))
            next_state_s = ST_ERR;
          else
            next_state_s = ST_SAMPLE;
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode, computed from the next state so the outputs can be registered.
  always_comb begin
    demod_en_s  = (next_state_s == ST_SETTLE) || (next_state_s == ST_SAMPLE);
    busy_s      = demod_en_s;
    // Results publish one cycle after DONE entry, while the accumulator still holds the run.
    res_valid_s = !bus.abort && (state_r == ST_DONE) && (state_prev_r != ST_DONE);
    if (bus.abort)
      err_s = err_r;
    else if (start_ok_s)
      err_s = 1'b0;
    else if ((state_r == ST_SAMPLE) && (next_state_s == ST_ERR))
      err_s = 1'b1;
    else
      err_s = err_r;
  end

  // Registered outputs and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demod_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      err_r       <= 1'b0;
      res_ma_r    <= 8'd0;
      res_freq_r  <= 8'd0;
    end else begin
      demod_en_r  <= demod_en_s;
      busy_r      <= busy_s;
      res_valid_r <= res_valid_s;
      err_r       <= err_s;
      if (res_valid_s) begin
        res_ma_r   <= 8'(acc_r >> LOG2N);
        res_freq_r <= prev_freq_r;
      end else begin
        res_ma_r   <= res_ma_r;
        res_freq_r <= res_freq_r;
      end
    end
  end

  // Cycle counter, sample/try counters, accumulator and previous-sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_r   <= CW'(0);
      samp_cnt_r  <= SW'(0);
      try_cnt_r   <= TW'(0);
      acc_r       <= AW'(0);
      prev_ma_r   <= 8'd0;
      prev_freq_r <= 8'd0;
    end else if (bus.abort) begin
      // A sample landing on the abort edge is dropped.
      cyc_cnt_r <= CW'(0);
    end else if (start_ok_s) begin
      cyc_cnt_r   <= CW'(0);
      samp_cnt_r  <= SW'(0);
      try_cnt_r   <= TW'(0);
      acc_r       <= AW'(0);
      prev_ma_r   <= 8'd0;
      prev_freq_r <= 8'd0;
    end else begin
      case (state_r)
        ST_SETTLE: begin
          if (settle_tc_s) cyc_cnt_r <= CW'(0);
          else             cyc_cnt_r <= cyc_cnt_r + CW'(1);
        end
        ST_SAMPLE: begin
          if (win_tc_s) begin
            cyc_cnt_r <= CW'(0);
            if (!samp_full_s) begin
              prev_ma_r   <= ma_c_s;
              prev_freq_r <= bus.freq_in;
              if (stable_s) begin
                acc_r      <= acc_r + AW'(ma_c_s);
                samp_cnt_r <= samp_cnt_r + SW'(1);
              end else begin
                acc_r      <= AW'(ma_c_s);
                samp_cnt_r <= SW'(1);
                try_cnt_r  <= try_inc_s;
              end
            end else begin
              samp_cnt_r <= samp_cnt_r;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
          end
        end
        default: cyc_cnt_r <= CW'(0);
      endcase
    end
  end

endmodule

// File: tb/tb_am_meas_ctrl.sv
// tb_am_meas_ctrl -- directed testbench for am_meas_ctrl with
// SETTLE_CYC=4, WIN_CYC=8, N_AVG=4, MA_TOL=2, MAX_TRY=3.
// Samples fall on edges 12, 20, 28, 36, ... after the edge that takes start.
module tb_am_meas_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  am_meas_ctrl_if bus ();

  am_meas_ctrl #(
    .SETTLE_CYC (4),
    .WIN_CYC    (8),
    .N_AVG      (4),
    .MA_TOL     (2),
    .MAX_TRY    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one measurement. mas/frs hold per-sample values (byte k = sample k).
  // busy_start_at: edge index after which start is pulsed while busy (0 = none).
  // abort_at: edge index at which abort is sampled (0 = none).
  // n returns the edge index of res_valid/err/abort, or -1 on timeout.
  task automatic measure(input logic [63:0] mas, input logic [63:0] frs,
                         input int busy_start_at, input int abort_at,
                         output int n, output logic gv, output logic ge);
    int k;
    n  = -1;
    gv = 1'b0;
    ge = 1'b0;
    @(negedge clk);
    bus.ma_in   = mas[7:0];
    bus.freq_in = frs[7:0];
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      if (abort_at != 0 && i == abort_at) bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (bus.res_valid) begin
        gv = 1'b1;
        n  = i;
        break;
      end
      if (bus.err) begin
        ge = 1'b1;
        n  = i;
        break;
      end
      if (abort_at != 0 && i == abort_at) begin
        n = i;
        break;
      end
      if (busy_start_at != 0 && i == busy_start_at) bus.start = 1'b1;
      if (i >= 12 && ((i - 4) % 8) == 0) begin
        k = (i - 4) / 8;
        if (k <= 7) begin
          bus.ma_in   = mas[k*8 +: 8];
          bus.freq_in = frs[k*8 +: 8];
        end
      end
    end
  endtask

  int   n;
  logic gv, ge;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.ma_in   = 8'd0;
    bus.freq_in = 8'd0;
    #12;
    chk("rst_demod_en", {31'd0, bus.demod_en}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_res", {14'd0, bus.res_valid, bus.err, bus.res_ma, bus.res_freq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Steady input: result 38 edges after start.
    measure({8{8'd50}}, {8{8'd2}}, 0, 0, n, gv, ge);
    chk("steady_lat", 32'(n), 32'd38);
    chk("steady_valid", {31'd0, gv}, 32'd1);
    chk("steady_ma", {24'd0, bus.res_ma}, 32'd50);
    chk("steady_freq", {24'd0, bus.res_freq}, 32'd2);
    chk("steady_err", {31'd0, bus.err}, 32'd0);
    chk("steady_demod_off", {31'd0, bus.demod_en}, 32'd0);
    @(posedge clk); #1;
    chk("steady_pulse_1cyc", {31'd0, bus.res_valid}, 32'd0);
    chk("steady_busy_off", {31'd0, bus.busy}, 32'd0);

    // Averaging 40,41,42,41 -> 164>>2 = 41, with a start pulse ignored while busy.
    measure({32'd0, 8'd41, 8'd42, 8'd41, 8'd40}, {8{8'd3}}, 6, 0, n, gv, ge);
    chk("avg_lat", 32'(n), 32'd38);
    chk("avg_ma", {24'd0, bus.res_ma}, 32'd41);
    chk("avg_freq", {24'd0, bus.res_freq}, 32'd3);

    // Changes of exactly MA_TOL are stable: 50,52,50,52 -> 204>>2 = 51.
    measure({32'd0, 8'd52, 8'd50, 8'd52, 8'd50}, {8{8'd4}}, 0, 0, n, gv, ge);
    chk("tol_lat", 32'(n), 32'd38);
    chk("tol_ma", {24'd0, bus.res_ma}, 32'd51);

    // A jump of 3 restarts the average: 50 then 53 x4 -> done after 5 samples.
    measure({{7{8'd53}}, 8'd50}, {8{8'd6}}, 0, 0, n, gv, ge);
    chk("restart_lat", 32'(n), 32'd46);
    chk("restart_ma", {24'd0, bus.res_ma}, 32'd53);
    chk("restart_err", {31'd0, bus.err}, 32'd0);

    // Frequency changes every sample: third restart at edge 36 -> ERR.
    measure({8{8'd30}}, {32'd0, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 0, n, gv, ge);
    chk("unstab_lat", 32'(n), 32'd36);
    chk("unstab_err", {31'd0, ge}, 32'd1);
    chk("unstab_novalid", {31'd0, gv}, 32'd0);
    chk("unstab_demod", {31'd0, bus.demod_en}, 32'd0);
    chk("unstab_busy", {31'd0, bus.busy}, 32'd0);
    chk("unstab_res_kept", {24'd0, bus.res_ma}, 32'd53);

    // Abort in ERR keeps err; abort+start together stays idle and keeps err.
    @(negedge clk); bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    chk("abort_err_kept", {31'd0, bus.err}, 32'd1);
    @(negedge clk); bus.abort = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_start_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_start_err", {31'd0, bus.err}, 32'd1);

    // Abort on the second sample edge: idle at once, results kept, err cleared by the start.
    measure({8{8'd60}}, {8{8'd5}}, 0, 20, n, gv, ge);
    chk("abort_novalid", {30'd0, gv, bus.res_valid}, 32'd0);
    chk("abort_demod", {31'd0, bus.demod_en}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_res_kept", {16'd0, bus.res_ma, bus.res_freq}, {16'd0, 8'd53, 8'd6});
    chk("abort_err_clr", {31'd0, bus.err}, 32'd0);
    gv = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.busy) gv = 1'b1;
    end
    chk("abort_stays_idle", {31'd0, gv}, 32'd0);

    // A later start measures afresh.
    measure({8{8'd60}}, {8{8'd5}}, 0, 0, n, gv, ge);
    chk("fresh_lat", 32'(n), 32'd38);
    chk("fresh_res", {16'd0, bus.res_ma, bus.res_freq}, {16'd0, 8'd60, 8'd5});

    // Reset mid-SETTLE clears everything asynchronously.
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_demod_busy", {30'd0, bus.demod_en, bus.busy}, 32'd0);
    chk("arst_res", {14'd0, bus.res_valid, bus.err, bus.res_ma, bus.res_freq}, 32'd0);
    @(negedge clk); rst = 1'b0;
    gv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.busy || bus.demod_en) gv = 1'b1;
    end
    chk("arst_idle", {31'd0, gv}, 32'd0);

    // ma_in above 100 clamps to 100.
    measure({8{8'd120}}, {8{8'd7}}, 0, 0, n, gv, ge);
    chk("clamp_lat", 32'(n), 32'd38);
    chk("clamp_res", {16'd0, bus.res_ma, bus.res_freq}, {16'd0, 8'd100, 8'd7});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
